imuldiv_muldiv_frontend: RTL
============================

// Module: imuldiv_muldiv_frontend
// PURPOSE
//  Request dispatcher / response sequencer in front of the iterative mul and div units.
//  - Accepts one muldiv request stream {fn, a, b} and issues each op to the mul or div unit.
//  - Records issued ops in an in-order tag FIFO.
//  - Returns results in request order, formatted per fn, on one 64-bit response stream.
// PARAMETERS
//  DEPTH   2   max ops in flight (tag FIFO entries); power of two, >= 2
// PORTS
//  clk                  in   1   clock
//  reset                in   1   reset, synchronous, active-high
//  muldivreq_msg_fn     in   3   0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 invalid
//  muldivreq_msg_a      in   32  operand a
//  muldivreq_msg_b      in   32  operand b
//  muldivreq_val        in   1   request valid
//  muldivreq_rdy        out  1   request ready
//  mulreq_msg_a/_b      out  32  to mul unit (muldivreq_msg_a/_b passed through)
//  mulreq_val           out  1   to mul unit
//  mulreq_rdy           in   1   from mul unit
//  mulresp_msg_result   in   64  signed 64-bit product
//  mulresp_val          in   1   from mul unit
//  mulresp_rdy          out  1   to mul unit
//  divreq_msg_a/_b      out  32  to div unit (muldivreq_msg_a/_b passed through)
//  divreq_msg_fn        out  1   1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//  divreq_val           out  1   to div unit
//  divreq_rdy           in   1   from div unit
//  divresp_msg_result   in   64  {rem[31:0], quot[31:0]}
//  divresp_val          in   1   from div unit
//  divresp_rdy          out  1   to div unit
//  muldivresp_msg_result out 64  formatted result
//  muldivresp_val       out  1   response valid
//  muldivresp_rdy       in   1   response ready
// BEHAVIOUR
//  Reset: FIFO empty; count = 0.
//  - Outputs in reset: muldivreq_rdy = 0, muldivresp_val = 0.
//  - All unit val/rdy outputs = 0.
//  - Reset mid-operation flushes all tags; the units share the same reset.
//  Issue (combinational, 0-cycle):
//  - tgt_rdy = mulreq_rdy for MUL, divreq_rdy for DIV..REMU, 1 for invalid fn.
//  - muldivreq_rdy = !reset && !full && tgt_rdy.
//  - mulreq_val = muldivreq_val && fn==MUL && !full.
//  - divreq_val = muldivreq_val && fn in 1..4 && !full.
//  - Unit rdy inputs never depend on val, so there is no combinational loop.
//  - Accept (val && rdy) pushes {fn} into the tag FIFO.
//  - Invalid fn is accepted and pushed; no unit is issued.
//  Full/empty:
//  - full = (count == DEPTH). There is no push-through-pop bypass: when full, rdy = 0 even if a pop occurs that cycle.
//  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH.
//  Response (combinational, 0-cycle, strictly in order):
//  - muldivresp_val: head fn MUL -> mulresp_val; head fn div-class -> divresp_val; head invalid -> 1.
//  - The invalid-fn response is therefore valid no earlier than the cycle after acceptance.
//  - Empty FIFO: muldivresp_val = 0 and mulresp_rdy = divresp_rdy = 0.
//  - mulresp_rdy = !empty && head==MUL && muldivresp_rdy.
//  - divresp_rdy = !empty && head is div-class && muldivresp_rdy.
//  - A unit response not matching the head is held off (rdy = 0); units are single-issue, so this only occurs transiently.
//  - Pop on muldivresp_val && muldivresp_rdy.
//  Formatting:
//  - MUL -> full 64-bit product.
//  - DIV -> sign-extend quot to 64 bits.
//  - DIVU -> zero-extend quot.
//  - REM -> sign-extend rem.
//  - REMU -> zero-extend rem.
//  - Invalid -> 64'h0.
//  Count tracks outstanding ops 0..DEPTH; it never underflows because pop requires !empty.
// STRUCTURE
//  Shared header imuldiv-MulDivReqMsg.v holds:
//  - fn encodings MUL/DIV/DIVU/REM/REMU.
//  - Message field widths.
//  Sub-module imuldiv_muldiv_tag_fifo (DEPTH x 3-bit):
//  - Ports: push, pop, head, full, empty.
//  - Implements pointers and count.
//  The top level holds the issue/steer logic, response mux, and result formatting.
// TESTING
//  1. MUL a=-3, b=7 -> mulreq_val=1 same cycle; muldivresp_msg_result = 64'hFFFF_FFFF_FFFF_FFEB.
//  2. DIV a=-7, b=2, then REMU a=7, b=2 -> responses in order:
//     - first: 64'hFFFF_FFFF_FFFF_FFFD;
//     - second: 64'h0000_0000_0000_0001.
//  3. MUL then DIV back-to-back, div unit finishes first -> divresp_rdy=0 until the MUL response pops; order MUL, DIV.
//  4. DEPTH=2: three reqs with muldivresp_rdy=0 -> third sees muldivreq_rdy=0; one pop -> rdy=1 next cycle, not same cycle.
//  5. fn=6 -> accepted, no mul/div val; next cycle muldivresp_val=1, result=0.
//  6. Assert reset with 2 ops in flight -> next cycle count=0, muldivresp_val=0, muldivreq_rdy=0.
//     After deassert, MUL 5x5 -> result 25.

Source files
------------

// File: rtl/imuldiv_muldiv_pkg.sv
// Shared definitions for the mul/div front end: function codes, message
// widths and the result formatting rule applied to unit responses.
package imuldiv_muldiv_pkg;

  localparam int FN_W     = 3;
  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  // Function codes carried on the request stream; 5..7 are not defined.
  typedef enum logic [FN_W-1:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4
  } muldiv_fn_e;

  function automatic logic fn_is_mul(input logic [FN_W-1:0] fn);
    return fn == FN_MUL;
  endfunction

  function automatic logic fn_is_div(input logic [FN_W-1:0] fn);
    return (fn == FN_DIV) || (fn == FN_DIVU) || (fn == FN_REM) || (fn == FN_REMU);
  endfunction

  // Signed divide/remainder select the signed mode of the div unit.
  function automatic logic fn_is_signed_div(input logic [FN_W-1:0] fn);
    return (fn == FN_DIV) || (fn == FN_REM);
  endfunction

  // Shape a unit result for the response stream. The div unit returns
  // {rem, quot}; each half is extended to 64 bits according to fn.
  function automatic logic [RESULT_W-1:0] format_result(
    input logic [FN_W-1:0]     fn,
    input logic [RESULT_W-1:0] mul_result,
    input logic [RESULT_W-1:0] div_result
  );
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    quot = div_result[DATA_W-1:0];
    rem  = div_result[RESULT_W-1:DATA_W];
    case (fn)
      FN_MUL:  return mul_result;
      FN_DIV:  return {{DATA_W{quot[DATA_W-1]}}, quot};
      FN_DIVU: return {{DATA_W{1'b0}}, quot};
      FN_REM:  return {{DATA_W{rem[DATA_W-1]}}, rem};
      FN_REMU: return {{DATA_W{1'b0}}, rem};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_tag_fifo.sv
// In-order tag FIFO recording the fn of every accepted request so that
// responses can be returned in request order. DEPTH must be a power of two.
module imuldiv_muldiv_tag_fifo
  import imuldiv_muldiv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been written, and count gates every read.
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imuldiv_muldiv_frontend.sv
// Request dispatcher / response sequencer in front of the iterative mul and
// div units. Requests are steered to a unit in the cycle they arrive, their
// fn is queued, and responses are drained strictly in request order.
module imuldiv_muldiv_frontend
  import imuldiv_muldiv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [FN_W-1:0]     muldivreq_msg_fn,
  input  logic [DATA_W-1:0]   muldivreq_msg_a,
  input  logic [DATA_W-1:0]   muldivreq_msg_b,
  input  logic                muldivreq_val,
  output logic                muldivreq_rdy,

  output logic [DATA_W-1:0]   mulreq_msg_a,
  output logic [DATA_W-1:0]   mulreq_msg_b,
  output logic                mulreq_val,
  input  logic                mulreq_rdy,

  input  logic [RESULT_W-1:0] mulresp_msg_result,
  input  logic                mulresp_val,
  output logic                mulresp_rdy,

  output logic [DATA_W-1:0]   divreq_msg_a,
  output logic [DATA_W-1:0]   divreq_msg_b,
  output logic                divreq_msg_fn,
  output logic                divreq_val,
  input  logic                divreq_rdy,

  input  logic [RESULT_W-1:0] divresp_msg_result,
  input  logic                divresp_val,
  output logic                divresp_rdy,

  output logic [RESULT_W-1:0] muldivresp_msg_result,
  output logic                muldivresp_val,
  input  logic                muldivresp_rdy
);

  logic            full;
  logic            empty;
  logic [FN_W-1:0] head_fn;
  logic            push;
  logic            pop;
  logic            tgt_rdy;
  logic            head_is_mul;
  logic            head_is_div;

  // Operands go to both units unchanged; only the val strobes steer.
  assign mulreq_msg_a  = muldivreq_msg_a;
  assign mulreq_msg_b  = muldivreq_msg_b;
  assign divreq_msg_a  = muldivreq_msg_a;
  assign divreq_msg_b  = muldivreq_msg_b;
  assign divreq_msg_fn = fn_is_signed_div(muldivreq_msg_fn);

  assign push = muldivreq_val && muldivreq_rdy;
  assign pop  = muldivresp_val && muldivresp_rdy;

  // Issue: pick the target unit's ready, gate on FIFO space and reset.
  // Unit ready inputs never depend on our val, so this has no loop.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    tgt_rdy    = 1'b1;
    mulreq_val = 1'b0;
    divreq_val = 1'b0;
    if (fn_is_mul(muldivreq_msg_fn))      tgt_rdy = mulreq_rdy;
    else if (fn_is_div(muldivreq_msg_fn)) tgt_rdy = divreq_rdy;
    muldivreq_rdy = !reset && !full && tgt_rdy;
    if (!reset && !full && muldivreq_val) begin
      mulreq_val = fn_is_mul(muldivreq_msg_fn);
      divreq_val = fn_is_div(muldivreq_msg_fn);
    end
  end

  // Response: only the unit matching the FIFO head may hand over a result;
  // an invalid-fn head completes on its own with a zero result.
  always_comb begin
    head_is_mul           = !empty && fn_is_mul(head_fn);
    head_is_div           = !empty && fn_is_div(head_fn);
    muldivresp_val        = 1'b0;
    mulresp_rdy           = 1'b0;
    divresp_rdy           = 1'b0;
    muldivresp_msg_result = format_result(head_fn, mulresp_msg_result, divresp_msg_result);
    if (!reset && !empty) begin
      if (head_is_mul)      muldivresp_val = mulresp_val;
      else if (head_is_div) muldivresp_val = divresp_val;
      else                  muldivresp_val = 1'b1;
      mulresp_rdy = head_is_mul && muldivresp_rdy;
      divresp_rdy = head_is_div && muldivresp_rdy;
    end
  end

  imuldiv_muldiv_tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FN_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (muldivreq_msg_fn),
    .pop       (pop),
    .head      (head_fn),
    .full      (full),
    .empty     (empty)
  );

endmodule
